// File: rtl/wb_unit.sv
// ---------------------------------------------------------------------------
// wb_unit
// Write-back stage for the pipeline. It combines three things:
//   - the MEM/WB pipeline register;
//   - a four-way result select (ALU result, load data, link address,
//     upper immediate);
//   - sub-word load extraction with sign or zero extension.
// It drives the register-file write port and the forwarding-valid flag, and
// keeps a count of retired instructions.
//
// Parameters
//   DATA_W  datapath width (32 or 64)
//   REG_AW  register address width
//   CNT_W   retired-instruction counter width
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   valid_in     MEM stage presents a valid instruction
//   stall        hold the stage (inputs not sampled)
//   flush        kill the instruction being captured
//   wb_sel       result source: 00 alu, 01 load, 10 pc_plus4, 11 imm
//   mem_size     load size: 00 byte, 01 half, 10 word32, 11 full width
//   mem_signed   sign-extend (1) or zero-extend (0) the load lane
//   byte_off     load address bits [1:0]
//   alu_result, mem_data, pc_plus4, imm   candidate results
//   rd_addr, reg_write                    destination and write intent
//   rf_we        one-cycle write pulse per captured writing instruction
//   rf_waddr     write address (stage register)
//   rf_wdata     write data (stage register)
//   fwd_valid    stage holds a pending write usable for forwarding
//   retired      count of retired valid instructions (wraps)
// ---------------------------------------------------------------------------
module wb_unit #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  input  logic              stall,
  input  logic              flush,
  input  logic [1:0]        wb_sel,
  input  logic [1:0]        mem_size,
  input  logic              mem_signed,
  input  logic [1:0]        byte_off,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] mem_data,
  input  logic [DATA_W-1:0] pc_plus4,
  input  logic [DATA_W-1:0] imm,
  input  logic [REG_AW-1:0] rd_addr,
  input  logic              reg_write,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              fwd_valid,
  output logic [CNT_W-1:0]  retired
);

  logic [7:0]        byte_lane;
  logic [15:0]       half_lane;
  logic [31:0]       word_lane;
  logic [DATA_W-1:0] load_val;
  logic [DATA_W-1:0] result;
  logic              capture_v;
  logic              capture_we;

  logic              we_q;
  logic              first_q;
  logic [REG_AW-1:0] waddr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [CNT_W-1:0]  retired_q;

  // Lane extraction and extension. The lanes are cut out by shifting the raw
  // little-endian word right by the lane offset; the half lane only looks at
  // byte_off[1], so a misaligned half silently reads the aligned half.
  // Sign extension relies on casting a signed lane up to DATA_W.
  always_comb begin
    byte_lane = 8'(mem_data >> {byte_off, 3'b000});
    half_lane = 16'(mem_data >> {byte_off[1], 4'b0000});
    word_lane = mem_data[31:0];
    load_val  = mem_data;
    case (mem_size)
      2'b00:   load_val = mem_signed ? DATA_W'($signed(byte_lane)) : DATA_W'(byte_lane);
      2'b01:   load_val = mem_signed ? DATA_W'($signed(half_lane)) : DATA_W'(half_lane);
      2'b10:   load_val = mem_signed ? DATA_W'($signed(word_lane)) : DATA_W'(word_lane);
      default: load_val = mem_data;
    endcase
  end

  // Result select plus the valid / write-enable terms for the capture.
  // A flushed instruction still loads its address and data, it just never
  // becomes valid; r0 is never written, but its data is still captured.
  always_comb begin
    result = alu_result;
    case (wb_sel)
      2'b00:   result = alu_result;
      2'b01:   result = load_val;
      2'b10:   result = pc_plus4;
      default: result = imm;
    endcase
    capture_v  = valid_in & ~flush;
    capture_we = capture_v & reg_write & (rd_addr != '0);
  end

  // Stage register. 'first_q' marks the cycle straight after a capture, so
  // rf_we pulses once even when the stage is then held by a stall. During a
  // stall only flush can act: it kills the pending write and keeps
  // address/data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q      <= 1'b0;
      first_q   <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      retired_q <= '0;
    end else if (!stall) begin
      we_q    <= capture_we;
      first_q <= 1'b1;
      waddr_q <= rd_addr;
      wdata_q <= result;
      if (capture_v) begin
        retired_q <= retired_q + CNT_W'(1);
      end
    end else begin
      first_q <= 1'b0;
      if (flush) begin
        we_q <= 1'b0;
      end
    end
  end

  assign rf_we     = we_q & first_q;
  assign fwd_valid = we_q;
  assign rf_waddr  = waddr_q;
  assign rf_wdata  = wdata_q;
  assign retired   = retired_q;

endmodule

// File: tb/tb_wb_unit.sv
// ---------------------------------------------------------------------------
// tb_wb_unit
// Self-checking bench for wb_unit. It instantiates two copies of the DUT:
//   - a: DATA_W=32, CNT_W=32
//   - b: DATA_W=64, CNT_W=4
// Both copies share control inputs. Copy a sees the low half of the 64-bit
// data inputs.
// Expected values come from a reference model that applies the write-back
// rules to whole instructions (pending write, pulse owed, retired count).
// ---------------------------------------------------------------------------
module tb_wb_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_in, stall, flush, reg_write, mem_signed;
  logic [1:0]  wb_sel, mem_size, byte_off;
  logic [4:0]  rd_addr;
  logic [63:0] alu64, mem64, pc64, imm64;

  logic        a_we, a_fwd, b_we, b_fwd;
  logic [4:0]  a_waddr, b_waddr;
  logic [31:0] a_wdata, a_ret;
  logic [63:0] b_wdata;
  logic [3:0]  b_ret;

  // Reference model state.
  logic        m_pend, m_pulse;
  logic [4:0]  m_waddr;
  logic [31:0] m_wd32, m_ret32;
  logic [63:0] m_wd64;
  logic [3:0]  m_ret4;

  int cmp_count  = 0;
  int fail_count = 0;

  always #5 clk = ~clk;

  wb_unit #(.DATA_W(32), .REG_AW(5), .CNT_W(32)) dut_a (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .stall(stall), .flush(flush),
    .wb_sel(wb_sel), .mem_size(mem_size), .mem_signed(mem_signed), .byte_off(byte_off),
    .alu_result(alu64[31:0]), .mem_data(mem64[31:0]), .pc_plus4(pc64[31:0]), .imm(imm64[31:0]),
    .rd_addr(rd_addr), .reg_write(reg_write),
    .rf_we(a_we), .rf_waddr(a_waddr), .rf_wdata(a_wdata), .fwd_valid(a_fwd), .retired(a_ret)
  );

  wb_unit #(.DATA_W(64), .REG_AW(5), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .stall(stall), .flush(flush),
    .wb_sel(wb_sel), .mem_size(mem_size), .mem_signed(mem_signed), .byte_off(byte_off),
    .alu_result(alu64), .mem_data(mem64), .pc_plus4(pc64), .imm(imm64),
    .rd_addr(rd_addr), .reg_write(reg_write),
    .rf_we(b_we), .rf_waddr(b_waddr), .rf_wdata(b_wdata), .fwd_valid(b_fwd), .retired(b_ret)
  );

  // Value written back for a width-w datapath. The load lane is taken
  // arithmetically, then sign-filled above the lane width when requested.
  function automatic logic [63:0] ref_result(input int w, input logic [1:0] sel,
      input logic [1:0] size, input logic sgn, input logic [1:0] off,
      input logic [63:0] alu, input logic [63:0] mem, input logic [63:0] pc,
      input logic [63:0] im);
    logic [63:0] r, lane, lmask, wmask;
    int bits, sh;
    wmask = (w == 64) ? '1 : 64'h0000_0000_FFFF_FFFF;
    case (sel)
      2'b00:   r = alu;
      2'b10:   r = pc;
      2'b11:   r = im;
      default: begin
        case (size)
          2'b00:   begin bits = 8;  sh = 8 * int'(off); end
          2'b01:   begin bits = 16; sh = 16 * int'(off[1]); end
          2'b10:   begin bits = 32; sh = 0; end
          default: begin bits = w;  sh = 0; end
        endcase
        lmask = (bits == 64) ? '1 : ((64'd1 << bits) - 64'd1);
        lane  = (mem >> sh) & lmask;
        if (sgn && size != 2'b11 && lane[bits-1]) lane = lane | ~lmask;
        r = lane;
      end
    endcase
    return r & wmask;
  endfunction

  function automatic logic [70:0] pack_a();
    return {a_we, a_fwd, a_waddr, a_wdata, a_ret};
  endfunction

  function automatic logic [70:0] exp_a();
    return {m_pulse, m_pend, m_waddr, m_wd32, m_ret32};
  endfunction

  function automatic logic [74:0] pack_b();
    return {b_we, b_fwd, b_waddr, b_wdata, b_ret};
  endfunction

  function automatic logic [74:0] exp_b();
    return {m_pulse, m_pend, m_waddr, m_wd64, m_ret4};
  endfunction

  task automatic model_reset();
    m_pend = 0; m_pulse = 0; m_waddr = '0; m_wd32 = '0; m_wd64 = '0;
    m_ret32 = '0; m_ret4 = '0;
  endtask

  task automatic set_ctrl(input logic v, input logic rw, input logic st, input logic fl,
                          input logic [4:0] rd, input logic [1:0] sel);
    valid_in = v; reg_write = rw; stall = st; flush = fl; rd_addr = rd; wb_sel = sel;
  endtask

  // Predict what the coming edge does to the stage, then advance one cycle
  // and leave the bench 1 ns past the edge for sampling.
  task automatic applyStimulus();
    logic v;
    v = valid_in & ~flush;
    if (!rst_n) begin
      model_reset();
    end else if (!stall) begin
      m_pend  = v & reg_write & (rd_addr != 0);
      m_pulse = m_pend;
      m_waddr = rd_addr;
      m_wd32  = ref_result(32, wb_sel, mem_size, mem_signed, byte_off, alu64, mem64, pc64, imm64)[31:0];
      m_wd64  = ref_result(64, wb_sel, mem_size, mem_signed, byte_off, alu64, mem64, pc64, imm64);
      if (v) begin m_ret32 = m_ret32 + 1; m_ret4 = m_ret4 + 1; end
    end else begin
      m_pulse = 0;
      if (flush) m_pend = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    cmp_count++;
    if (pack_a() !== '0) begin fail_count++; $display("[TB] FAIL reset_a: got %h want 0", pack_a()); end
    cmp_count++;
    if (pack_b() !== '0) begin fail_count++; $display("[TB] FAIL reset_b: got %h want 0", pack_b()); end
    @(negedge clk);
    rst_n = 1;
    set_ctrl(1, 1, 0, 0, 5'd3, 2'b00);
    alu64 = 64'hDEADBEEF_CAFEF00D;
    applyStimulus();
    cmp_count++;
    if (a_we !== 1'b1) begin fail_count++; $display("[TB] FAIL pend_we: got %b want 1", a_we); end
    // Asynchronous reset in the middle of the cycle, with the write pending.
    #2 rst_n = 0;
    #1;
    model_reset();
    cmp_count++;
    if (pack_a() !== '0) begin fail_count++; $display("[TB] FAIL async_a: got %h want 0", pack_a()); end
    cmp_count++;
    if (pack_b() !== '0) begin fail_count++; $display("[TB] FAIL async_b: got %h want 0", pack_b()); end
    applyStimulus();
    rst_n = 1;
    set_ctrl(0, 0, 0, 0, 5'd0, 2'b00);
    applyStimulus();
    cmp_count++;
    if ({a_we, a_ret} !== 33'd0) begin fail_count++; $display("[TB] FAIL post_reset: got we=%b ret=%0d want 0 0", a_we, a_ret); end
    cmp_count++;
    if (pack_a() !== exp_a()) begin fail_count++; $display("[TB] FAIL post_reset_model: got %h want %h", pack_a(), exp_a()); end
    // Reset while a held instruction sits in the stage.
    set_ctrl(1, 1, 0, 0, 5'd4, 2'b00);
    applyStimulus();
    set_ctrl(1, 1, 1, 0, 5'd4, 2'b00);
    applyStimulus();
    #2 rst_n = 0;
    #1;
    model_reset();
    cmp_count++;
    if (a_fwd !== 1'b0) begin fail_count++; $display("[TB] FAIL stall_reset_fwd: got %b want 0", a_fwd); end
    #1 rst_n = 1;
    applyStimulus();
    cmp_count++;
    if ({a_we, a_fwd, a_ret} !== 34'd0) begin fail_count++; $display("[TB] FAIL stall_reset_hold: got we=%b fwd=%b ret=%0d want 0 0 0", a_we, a_fwd, a_ret); end
    set_ctrl(1, 1, 0, 0, 5'd6, 2'b00);
    applyStimulus();
    cmp_count++;
    if ({a_we, a_ret} !== {1'b1, 32'd1}) begin fail_count++; $display("[TB] FAIL stall_reset_next: got we=%b ret=%0d want 1 1", a_we, a_ret); end
  endtask

  task automatic test_loads();
    logic [1:0]  sz  [4] = '{2'b00, 2'b00, 2'b01, 2'b01};
    logic        sg  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [1:0]  off [4] = '{2'd2, 2'd1, 2'd2, 2'd0};
    logic [31:0] want[4] = '{32'hFFFFFFF1, 32'h0000007F, 32'hFFFF80F1, 32'h00007F22};
    mem64 = 64'h5A5A_A5A5_80F1_7F22;
    for (int i = 0; i < 4; i++) begin
      set_ctrl(1, 1, 0, 0, 5'd7, 2'b01);
      mem_size = sz[i]; mem_signed = sg[i]; byte_off = off[i];
      applyStimulus();
      cmp_count++;
      if ({a_we, a_wdata} !== {1'b1, want[i]}) begin fail_count++; $display("[TB] FAIL load_%0d: got we=%b data=%h want 1 %h", i, a_we, a_wdata, want[i]); end
      cmp_count++;
      if (pack_b() !== exp_b()) begin fail_count++; $display("[TB] FAIL load64_%0d: got %h want %h", i, pack_b(), exp_b()); end
    end
  endtask

  task automatic test_sources();
    logic [31:0] base;
    pc64 = 64'h104;
    set_ctrl(1, 1, 0, 0, 5'd31, 2'b10);
    applyStimulus();
    cmp_count++;
    if ({a_we, a_waddr, a_wdata} !== {1'b1, 5'd31, 32'h104}) begin fail_count++; $display("[TB] FAIL link_r31: got we=%b addr=%0d data=%h want 1 31 104", a_we, a_waddr, a_wdata); end
    base = m_ret32;
    set_ctrl(1, 1, 0, 0, 5'd0, 2'b10);
    applyStimulus();
    cmp_count++;
    if ({a_we, a_fwd, a_ret} !== {2'b00, base + 32'd1}) begin fail_count++; $display("[TB] FAIL link_r0: got we=%b fwd=%b ret=%0d want 0 0 %0d", a_we, a_fwd, a_ret, base + 1); end
  endtask

  task automatic test_stall();
    int we_cnt, fwd_cnt;
    logic [31:0] base;
    base = m_ret32;
    we_cnt = 0; fwd_cnt = 0;
    alu64 = 64'h12345678;
    set_ctrl(1, 1, 0, 0, 5'd5, 2'b00);
    for (int i = 0; i < 4; i++) begin
      applyStimulus();
      we_cnt  += int'(a_we);
      fwd_cnt += int'(a_fwd);
      stall = 1;
    end
    cmp_count++;
    if (we_cnt !== 1) begin fail_count++; $display("[TB] FAIL stall_we_count: got %0d want 1", we_cnt); end
    cmp_count++;
    if (fwd_cnt !== 4) begin fail_count++; $display("[TB] FAIL stall_fwd_count: got %0d want 4", fwd_cnt); end
    cmp_count++;
    if ({a_ret, a_waddr, a_wdata} !== {base + 32'd1, 5'd5, 32'h12345678}) begin fail_count++; $display("[TB] FAIL stall_hold: got ret=%0d addr=%0d data=%h want %0d 5 12345678", a_ret, a_waddr, a_wdata, base + 1); end
    set_ctrl(0, 0, 0, 0, 5'd2, 2'b00);
    applyStimulus();
    cmp_count++;
    if ({a_we, a_fwd} !== 2'b00) begin fail_count++; $display("[TB] FAIL stall_release: got we=%b fwd=%b want 0 0", a_we, a_fwd); end
  endtask

  task automatic test_flush();
    logic [31:0] base;
    base = m_ret32;
    set_ctrl(1, 1, 0, 1, 5'd7, 2'b00);
    applyStimulus();
    cmp_count++;
    if ({a_we, a_fwd, a_ret} !== {2'b00, base}) begin fail_count++; $display("[TB] FAIL flush: got we=%b fwd=%b ret=%0d want 0 0 %0d", a_we, a_fwd, a_ret, base); end
    alu64 = 64'h55;
    set_ctrl(1, 1, 0, 0, 5'd8, 2'b00);
    applyStimulus();
    alu64 = 64'h66;
    set_ctrl(1, 1, 1, 1, 5'd9, 2'b00);
    applyStimulus();
    cmp_count++;
    if ({a_we, a_fwd, a_waddr, a_wdata} !== {2'b00, 5'd8, 32'h55}) begin fail_count++; $display("[TB] FAIL flush_stall: got we=%b fwd=%b addr=%0d data=%h want 0 0 8 55", a_we, a_fwd, a_waddr, a_wdata); end
    cmp_count++;
    if (a_ret !== base + 32'd1) begin fail_count++; $display("[TB] FAIL flush_count: got %0d want %0d", a_ret, base + 1); end
    set_ctrl(0, 0, 0, 0, 5'd0, 2'b00);
    applyStimulus();
    cmp_count++;
    if (a_we !== 1'b0) begin fail_count++; $display("[TB] FAIL flush_release: got we=%b want 0", a_we); end
  endtask

  task automatic test_back_to_back();
    alu64 = 64'hAAAA;
    set_ctrl(1, 1, 0, 0, 5'd9, 2'b00);
    applyStimulus();
    cmp_count++;
    if ({a_we, a_waddr, a_wdata} !== {1'b1, 5'd9, 32'hAAAA}) begin fail_count++; $display("[TB] FAIL b2b_first: got we=%b addr=%0d data=%h want 1 9 aaaa", a_we, a_waddr, a_wdata); end
    alu64 = 64'hBBBB;
    applyStimulus();
    cmp_count++;
    if ({a_we, a_waddr, a_wdata} !== {1'b1, 5'd9, 32'hBBBB}) begin fail_count++; $display("[TB] FAIL b2b_second: got we=%b addr=%0d data=%h want 1 9 bbbb", a_we, a_waddr, a_wdata); end
  endtask

  task automatic test_counter_wrap();
    rst_n = 0;
    #1 model_reset();
    #1 rst_n = 1;
    for (int i = 0; i < 17; i++) begin
      set_ctrl(1, 1'($urandom_range(0, 1)), 0, 0, 5'($urandom), 2'b00);
      alu64 = {$urandom, $urandom};
      applyStimulus();
    end
    cmp_count++;
    if (b_ret !== 4'd1) begin fail_count++; $display("[TB] FAIL wrap_cnt4: got %0d want 1", b_ret); end
    cmp_count++;
    if (a_ret !== 32'd17) begin fail_count++; $display("[TB] FAIL count32: got %0d want 17", a_ret); end
  endtask

  task automatic test_wide();
    mem64 = 64'h12345678_80000000;
    set_ctrl(1, 1, 0, 0, 5'd10, 2'b01);
    mem_size = 2'b10; mem_signed = 1; byte_off = 2'd3;
    applyStimulus();
    cmp_count++;
    if (b_wdata !== 64'hFFFFFFFF_80000000) begin fail_count++; $display("[TB] FAIL w32_signed64: got %h want ffffffff80000000", b_wdata); end
    cmp_count++;
    if (a_wdata !== 32'h80000000) begin fail_count++; $display("[TB] FAIL w32_signed32: got %h want 80000000", a_wdata); end
    mem_signed = 0;
    applyStimulus();
    cmp_count++;
    if (b_wdata !== 64'h00000000_80000000) begin fail_count++; $display("[TB] FAIL w32_unsigned64: got %h want 0000000080000000", b_wdata); end
    mem_size = 2'b11; mem_signed = 1;
    applyStimulus();
    cmp_count++;
    if (b_wdata !== 64'h12345678_80000000) begin fail_count++; $display("[TB] FAIL full64: got %h want 1234567880000000", b_wdata); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      valid_in   = ($urandom_range(0, 3) != 0);
      reg_write  = ($urandom_range(0, 3) != 0);
      stall      = ($urandom_range(0, 3) == 0);
      flush      = ($urandom_range(0, 7) == 0);
      rd_addr    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      wb_sel     = 2'($urandom);
      mem_size   = 2'($urandom);
      mem_signed = 1'($urandom);
      byte_off   = 2'($urandom);
      alu64 = {$urandom, $urandom}; mem64 = {$urandom, $urandom};
      pc64  = {$urandom, $urandom}; imm64 = {$urandom, $urandom};
      applyStimulus();
      cmp_count++;
      if (pack_a() !== exp_a()) begin fail_count++; $display("[TB] FAIL rand_a[%0d]: got %h want %h", i, pack_a(), exp_a()); end
      cmp_count++;
      if (pack_b() !== exp_b()) begin fail_count++; $display("[TB] FAIL rand_b[%0d]: got %h want %h", i, pack_b(), exp_b()); end
    end
  endtask

  initial begin
    rst_n = 0;
    model_reset();
    set_ctrl(0, 0, 0, 0, 5'd0, 2'b00);
    mem_size = 0; mem_signed = 0; byte_off = 0;
    alu64 = '0; mem64 = '0; pc64 = '0; imm64 = '0;
    test_reset();
    test_loads();
    test_sources();
    test_stall();
    test_flush();
    test_back_to_back();
    test_counter_wrap();
    test_wide();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
    $finish;
  end

endmodule

// File: doc/wb_unit.md
# wb_unit

Parametrised write-back unit for the pipeline. It merges the MEM/WB pipeline register with a four-source result select and sub-word load extraction with sign/zero extension. It drives the register-file write port and a retired-instruction counter. It replaces the bare two-input write-back mux. The unit sits after the memory stage and feeds the register file and the forwarding unit.

## Interface
- DATA_W, 32: datapath width; legal values are 32 and 64.
- REG_AW, 5: register address width.
- CNT_W, 32: width of the retired-instruction counter.

- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- valid_in  in  1  MEM stage presents a valid instruction.
- stall  in  1  hold the stage; inputs are not sampled.
- flush  in  1  kill the instruction being captured.
- wb_sel  in  2  result source: 00 alu_result, 01 load data, 10 pc_plus4 (link), 11 imm.
- mem_size  in  2  load size: 00 byte, 01 half, 10 word32, 11 full DATA_W.
- mem_signed  in  1  1 = sign-extend, 0 = zero-extend.
- byte_off  in  2  load address bits [1:0].
- alu_result  in  DATA_W  ALU result.
- mem_data  in  DATA_W  raw load data, little-endian.
- pc_plus4  in  DATA_W  link address.
- imm  in  DATA_W  pre-shifted immediate (upper-immediate ops).
- rd_addr  in  REG_AW  destination register.
- reg_write  in  1  instruction writes a register.
- rf_we  out  1  register-file write enable, one-cycle pulse per instruction.
- rf_waddr  out  REG_AW  write address.
- rf_wdata  out  DATA_W  write data.
- fwd_valid  out  1  the held stage contents are a pending write usable for forwarding.
- retired  out  CNT_W  count of retired valid instructions.

## Operation
- Capture: on a rising edge with stall=0, the stage register loads the following:
  - v = valid_in & ~flush.
  - we = v & reg_write & (rd_addr != 0).
  - waddr = rd_addr.
  - wdata = the selected result.
- Load extraction (mem_data, little-endian):
  - byte: lane mem_data[8*byte_off+7 : 8*byte_off].
  - half: lane mem_data[16*byte_off[1]+15 : 16*byte_off[1]]; byte_off[0] is ignored (no misalignment trap).
  - word32: mem_data[31:0], byte_off ignored.
  - full: mem_data unchanged; mem_signed is ignored.
- Extension:
  - mem_signed=1 replicates the lane MSB up to DATA_W.
  - mem_signed=0 zero-fills.
  - With DATA_W=32, word32 and full are identical.
- Non-load sources: passed through unmodified; mem_size, mem_signed and byte_off are ignored.
- Writes to r0 are never issued; wdata is still captured.
- Output drive:
  - rf_waddr and rf_wdata come straight from the stage register.
  - rf_we = we & first, where first is set on each capture and cleared the cycle after. The write therefore pulses exactly once even if a stall holds the stage.
  - fwd_valid = we, and stays high for as long as the stage is held.
- Counter: retired increments by 1 on each capture with v=1, whether or not the instruction writes a register. It wraps modulo 2^CNT_W. Stalled cycles do not count.
- Priority: rst_n low beats flush, flush beats stall for the valid bit. With stall=1 and flush=1, v/we are cleared and first is cleared; data and address are held.

## Timing
- Latency: one cycle. Inputs sampled at edge N appear on rf_* after edge N; the register file writes at edge N+1.
- Throughput: one instruction per cycle when stall=0.
- Reset (asynchronous, rst_n=0) clears everything immediately, with no clock required:
  - rf_we=0, fwd_valid=0.
  - rf_waddr=0, rf_wdata=0.
  - retired=0.
- Reset mid-stall: the held instruction is discarded with no write. After rst_n rises, the first capture is the next edge with stall=0.
- Back-to-back writes to the same rd: each produces its own rf_we pulse on consecutive cycles, and the later value wins.
- Stall release: the held instruction does not write again. The newly captured one behaves normally.

## Test plan
- Reset and idle:
  - Stimulus: rst_n=0 asynchronously mid-cycle, with a write pending.
  - Response: rf_we, fwd_valid, rf_wdata and retired all drop to 0 immediately; no write occurs after release.
- Signed and unsigned byte/half loads:
  - Stimulus: mem_data=0x80F17F22 with wb_sel=01.
  - byte, off=2, signed -> rf_wdata=0xFFFFFFF1.
  - byte, off=1, unsigned -> 0x0000007F.
  - half, off=2, signed -> 0xFFFF80F1.
  - half, off=0, unsigned -> 0x00007F22.
- Sources and r0:
  - Stimulus: wb_sel=10 with pc_plus4=0x00000104 and rd=31.
  - Response: rf_we pulses, rf_waddr=31, rf_wdata=0x104.
  - Stimulus: the same with rd=0.
  - Response: rf_we=0, fwd_valid=0, retired still increments.
- Stall hold:
  - Stimulus: capture an ALU result of 0x12345678 to rd=5, then stall=1 for 3 cycles.
  - Response: rf_we high for exactly 1 cycle; fwd_valid high for 4 cycles; retired +1 in total.
- Flush:
  - Stimulus: valid_in=1, reg_write=1, flush=1 (including together with stall=1).
  - Response: no rf_we, fwd_valid=0, retired unchanged.
- Counter wrap and 64-bit mode:
  - Stimulus: CNT_W=4, 17 valid captures.
  - Response: retired=1.
  - Stimulus: DATA_W=64, word32 signed with mem_data[31:0]=0x80000000.
  - Response: rf_wdata=0xFFFFFFFF80000000.
